// File: rtl/avr_dmem_arbiter_if.sv
// Data-memory bus bundle shared by the AVR core port, the secondary master port and the SRAM port.
// The arbiter takes the slave view; the environment (core, secondary master, SRAM) takes the master view.
interface avr_dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/avr_dmem_arbiter.sv
// Single-port data SRAM arbiter: AVR core has priority, secondary master gets idle cycles.
// Define AVR_ARB_FAIR_EN to add the starvation guard that forces bounded secondary bursts.
module avr_dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8,
    parameter int EXT_BURST  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    avr_dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_EXT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] ext_hold_q, ext_hold_d;

    logic              ext_win;
    logic              cpu_gnt;
    logic              ext_gnt;
    logic [1:0]        rd_owner;
    logic              cpu_ret;
    logic              ext_ret;

`ifdef AVR_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(EXT_BURST + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(EXT_BURST);

    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] cnt);
        return (cnt == STARVE_TOP) ? cnt : cnt + SW'(1);
    endfunction

    // A forced burst continues only while it was started by the starvation guard
    always_comb begin
        ext_win = bus.ext_req &&
                  (!bus.cpu_req ||
                   (starve_q == STARVE_TOP) ||
                   (state_q == ST_EXT && burst_q != '0 && burst_q < BURST_TOP));
    end
`else
    always_comb begin
        ext_win = bus.ext_req && !bus.cpu_req;
    end
`endif

    always_comb begin
        cpu_gnt = !RST && bus.cpu_req && !ext_win;
        ext_gnt = !RST && ext_win;

        bus.mem_en    = cpu_gnt || ext_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ext_gnt) begin
            bus.mem_we    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end

        bus.cpu_stall = !RST && bus.cpu_req && !cpu_gnt;
        bus.ext_gnt   = ext_gnt;

        state_d   = cpu_gnt ? ST_CPU : (ext_gnt ? ST_EXT : ST_IDLE);
        rd_pend_d = (cpu_gnt && !bus.cpu_we) || (ext_gnt && !bus.ext_we);

        // Read tag is the previous owner qualified by "that access was a read"
        rd_owner = rd_pend_q ? state_q : ST_IDLE;
        cpu_ret  = !RST && (rd_owner == ST_CPU);
        ext_ret  = !RST && (rd_owner == ST_EXT);

        cpu_hold_d = cpu_ret ? bus.mem_rdata : cpu_hold_q;
        ext_hold_d = ext_ret ? bus.mem_rdata : ext_hold_q;

        bus.cpu_rdata  = RST ? '0 : cpu_hold_d;
        bus.ext_rdata  = RST ? '0 : ext_hold_d;
        bus.ext_rvalid = ext_ret;
    end

`ifdef AVR_ARB_FAIR_EN
    always_comb begin
        starve_d = (!bus.ext_req || ext_gnt) ? '0 : sat_inc(starve_q);
        burst_d  = burst_q;
        if (!bus.cpu_req || cpu_gnt) begin
            burst_d = '0;
        end else if (ext_gnt) begin
            burst_d = burst_q + BW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rd_pend_q  <= 1'b0;
            cpu_hold_q <= '0;
            ext_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            cpu_hold_q <= cpu_hold_d;
            ext_hold_q <= ext_hold_d;
        end
    end
endmodule
